// File: rtl/mips_defs.sv
// Shared MIPS pipeline definitions: next-PC select encodings, reset vector,
// nop encoding and the instruction-window fetch check.
package mips_defs;

  typedef enum logic [1:0] {
    PCSEL_PC4 = 2'd0,
    PCSEL_NPC = 2'd1,
    PCSEL_REG = 2'd2,
    PCSEL_RSV = 2'd3
  } pcsel_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] IM_BYTES_DEF = 32'h0000_1000;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0000;
  localparam logic [31:0] PC_STEP      = 32'h0000_0004;

  // Window check is done in 33 bits so base + size cannot wrap.
  function automatic logic fetch_err(input logic [31:0] pc,
                                     input logic [31:0] base,
                                     input logic [31:0] size);
    logic [32:0] pc_w;
    logic [32:0] lo_w;
    logic [32:0] hi_w;
    logic        misaligned;
    pc_w       = {1'b0, pc};
    lo_w       = {1'b0, base};
    hi_w       = {1'b0, base} + {1'b0, size};
    misaligned = (pc[1:0] != 2'b00);
    return misaligned || (pc_w < lo_w) || (pc_w >= hi_w);
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: reset clears, stall holds every field, flush loads a bubble.
module if_id_reg
  import mips_defs::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] pc_in,
  input  logic [31:0] pc4_in,
  input  logic [31:0] instr_in,
  input  logic        err_in,
  output logic [31:0] pc_out,
  output logic [31:0] pc4_out,
  output logic [31:0] instr_out,
  output logic        valid_out,
  output logic        err_out
);

  logic [31:0] pc_d, pc_q;
  logic [31:0] pc4_d, pc4_q;
  logic [31:0] instr_d, instr_q;
  logic        valid_d, valid_q;
  logic        err_d, err_q;

  // Next-state selection; stall outranks flush so a held redirect is not lost.
  always_comb begin
    pc_d    = pc_q;
    pc4_d   = pc4_q;
    instr_d = instr_q;
    valid_d = valid_q;
    err_d   = err_q;
    if (stall) begin
      pc_d    = pc_q;
      pc4_d   = pc4_q;
      instr_d = instr_q;
      valid_d = valid_q;
      err_d   = err_q;
    end else if (flush) begin
      pc_d    = 32'h0000_0000;
      pc4_d   = 32'h0000_0000;
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
      err_d   = 1'b0;
    end else begin
      pc_d    = pc_in;
      pc4_d   = pc4_in;
      instr_d = instr_in;
      valid_d = 1'b1;
      err_d   = err_in;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= 32'h0000_0000;
      pc4_q   <= 32'h0000_0000;
      instr_q <= NOP_INSTR;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      pc4_q   <= pc4_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end

  assign pc_out    = pc_q;
  assign pc4_out   = pc4_q;
  assign instr_out = instr_q;
  assign valid_out = valid_q;
  assign err_out   = err_q;

endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, next-PC mux, fetch-address check
// and the IF/ID register feeding decode.
module fetch_stage
  import mips_defs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] IM_BYTES = IM_BYTES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Stall,
  input  logic        Flush_D,
  input  logic [1:0]  PCSel,
  input  logic [31:0] NPC,
  input  logic [31:0] RegJump,
  input  logic [31:0] Instr_F,
  output logic [31:0] PC_F,
  output logic [31:0] PC_D,
  output logic [31:0] PC4_D,
  output logic [31:0] Instr_D,
  output logic        Valid_D,
  output logic        FetchErr_D
);

  logic [31:0] pc_d, pc_q;
  logic [31:0] pc4_f_s;
  logic [31:0] next_pc_s;
  logic        err_f_s;
  logic [31:0] instr_f_s;

  assign pc4_f_s = pc_q + PC_STEP;
  assign err_f_s = fetch_err(pc_q, RESET_PC, IM_BYTES);

  // Faulting fetches present a nop so nothing from a bad address reaches decode.
  always_comb begin
    instr_f_s = Instr_F;
    if (err_f_s) begin
      instr_f_s = NOP_INSTR;
    end else begin
      instr_f_s = Instr_F;
    end
  end

  // Next-PC mux; the reserved select falls back to sequential fetch.
  always_comb begin
    next_pc_s = pc4_f_s;
    case (pcsel_e'(PCSel))
      PCSEL_PC4: next_pc_s = pc4_f_s;
      PCSEL_NPC: next_pc_s = NPC;
      PCSEL_REG: next_pc_s = RegJump;
      default:   next_pc_s = pc4_f_s;
    endcase
  end

  // PC update: stall holds; flush does not stop the PC from advancing.
  always_comb begin
    pc_d = pc_q;
    if (Stall) begin
      pc_d = pc_q;
    end else begin
      pc_d = next_pc_s;
    end
  end

  // Program counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign PC_F = pc_q;

  if_id_reg u_if_id (
    .clk       (clk),
    .reset     (reset),
    .stall     (Stall),
    .flush     (Flush_D),
    .pc_in     (pc_q),
    .pc4_in    (pc4_f_s),
    .instr_in  (instr_f_s),
    .err_in    (err_f_s),
    .pc_out    (PC_D),
    .pc4_out   (PC4_D),
    .instr_out (Instr_D),
    .valid_out (Valid_D),
    .err_out   (FetchErr_D)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; the instruction memory returns PC ^ 32'hDEAD_0000.
module tb_fetch_stage;

  logic        clk;
  logic        reset;
  logic        Stall;
  logic        Flush_D;
  logic [1:0]  PCSel;
  logic [31:0] NPC;
  logic [31:0] RegJump;
  logic [31:0] Instr_F;
  logic [31:0] PC_F;
  logic [31:0] PC_D;
  logic [31:0] PC4_D;
  logic [31:0] Instr_D;
  logic        Valid_D;
  logic        FetchErr_D;

  int errors = 0;
  int checks = 0;

  fetch_stage dut (
    .clk        (clk),
    .reset      (reset),
    .Stall      (Stall),
    .Flush_D    (Flush_D),
    .PCSel      (PCSel),
    .NPC        (NPC),
    .RegJump    (RegJump),
    .Instr_F    (Instr_F),
    .PC_F       (PC_F),
    .PC_D       (PC_D),
    .PC4_D      (PC4_D),
    .Instr_D    (Instr_D),
    .Valid_D    (Valid_D),
    .FetchErr_D (FetchErr_D)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign Instr_F = PC_F ^ 32'hDEAD_0000;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_d(input string tag, input logic [31:0] pc_f, input logic [31:0] pc_d,
                         input logic [31:0] pc4_d, input logic [31:0] instr_d,
                         input logic valid_d, input logic err_d);
    check_val({tag, ".PC_F"}, PC_F, pc_f);
    check_val({tag, ".PC_D"}, PC_D, pc_d);
    check_val({tag, ".PC4_D"}, PC4_D, pc4_d);
    check_val({tag, ".Instr_D"}, Instr_D, instr_d);
    check_val({tag, ".Valid_D"}, {31'd0, Valid_D}, {31'd0, valid_d});
    check_val({tag, ".FetchErr_D"}, {31'd0, FetchErr_D}, {31'd0, err_d});
  endtask

  initial begin
    reset = 1'b1; Stall = 1'b0; Flush_D = 1'b0; PCSel = 2'd0;
    NPC = 32'h0; RegJump = 32'h0;
    // Reset and sequential fetch
    tick(); tick();
    check_d("rst", 32'h3000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    reset = 1'b0;
    tick();
    check_d("seq1", 32'h3004, 32'h3000, 32'h3004, 32'hDEAD3000, 1'b1, 1'b0);
    tick();
    tick();
    check_d("seq3", 32'h300C, 32'h3008, 32'h300C, 32'hDEAD3008, 1'b1, 1'b0);

    // Branch with delay slot
    reset = 1'b1; tick(); tick();
    reset = 1'b0; tick(); tick();
    check_d("pre_br", 32'h3008, 32'h3004, 32'h3008, 32'hDEAD3004, 1'b1, 1'b0);
    PCSel = 2'd1; NPC = 32'h3040;
    tick();
    check_d("br_slot", 32'h3040, 32'h3008, 32'h300C, 32'hDEAD3008, 1'b1, 1'b0);
    PCSel = 2'd0;
    tick();
    check_d("br_tgt", 32'h3044, 32'h3040, 32'h3044, 32'hDEAD3040, 1'b1, 1'b0);

    // Stall with a pending jr redirect
    Stall = 1'b1; PCSel = 2'd2; RegJump = 32'h3100;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_d("stall", 32'h3044, 32'h3040, 32'h3044, 32'hDEAD3040, 1'b1, 1'b0);
    end
    Stall = 1'b0;
    tick();
    check_d("unstall", 32'h3100, 32'h3044, 32'h3048, 32'hDEAD3044, 1'b1, 1'b0);
    PCSel = 2'd0;
    tick();
    check_d("jr_tgt", 32'h3104, 32'h3100, 32'h3104, 32'hDEAD3100, 1'b1, 1'b0);

    // Flush, then flush masked by stall
    PCSel = 2'd1; NPC = 32'h3010;
    tick();
    check_val("to3010", PC_F, 32'h3010);
    PCSel = 2'd0; Flush_D = 1'b1;
    tick();
    check_d("flush", 32'h3014, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    Flush_D = 1'b0;
    tick();
    check_d("post_flush", 32'h3018, 32'h3014, 32'h3018, 32'hDEAD3014, 1'b1, 1'b0);
    Flush_D = 1'b1; Stall = 1'b1;
    tick();
    check_d("flush_stall", 32'h3018, 32'h3014, 32'h3018, 32'hDEAD3014, 1'b1, 1'b0);
    Flush_D = 1'b0; Stall = 1'b0;

    // Fetch errors: misaligned, above, below the window; top word is legal
    PCSel = 2'd2; RegJump = 32'h3002;
    tick();
    check_val("mis_pcf", PC_F, 32'h3002);
    PCSel = 2'd0;
    tick();
    check_d("mis", 32'h3006, 32'h3002, 32'h3006, 32'h0, 1'b1, 1'b1);
    PCSel = 2'd2; RegJump = 32'h4000;
    tick();
    PCSel = 2'd0;
    tick();
    check_d("hi", 32'h4004, 32'h4000, 32'h4004, 32'h0, 1'b1, 1'b1);
    PCSel = 2'd2; RegJump = 32'h3FFC;
    tick();
    PCSel = 2'd0;
    tick();
    check_d("top_ok", 32'h4000, 32'h3FFC, 32'h4000, 32'hDEAD3FFC, 1'b1, 1'b0);
    PCSel = 2'd2; RegJump = 32'h2FFC;
    tick();
    PCSel = 2'd0;
    tick();
    check_d("lo", 32'h3000, 32'h2FFC, 32'h3000, 32'h0, 1'b1, 1'b1);
    PCSel = 2'd2; RegJump = 32'hFFFF_FFFC;
    tick();
    PCSel = 2'd0;
    tick();
    check_d("wrap", 32'h0, 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b1, 1'b1);

    // Reset overrides stall and redirect
    reset = 1'b1; Stall = 1'b1; PCSel = 2'd1; NPC = 32'h3040;
    tick();
    check_d("rst_mid", 32'h3000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    reset = 1'b0; Stall = 1'b0; PCSel = 2'd0;
    tick();
    // Reserved select behaves as sequential fetch
    PCSel = 2'd3; RegJump = 32'h3100;
    tick();
    check_d("rsv", 32'h3008, 32'h3004, 32'h3008, 32'hDEAD3004, 1'b1, 1'b0);
    PCSel = 2'd0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
